uart_frame_scheduler: RTL and testbench

Sequencer between the XADC sample path and the UART transmitter. On a fixed cycle period it snapshots the latest 16-bit sample and drives the transmitter byte-by-byte with a 6-byte ASCII frame: four uppercase hex digits (MSB nibble first), then CR (0x0D) and LF (0x0A). It replaces ad-hoc enable/delay counting in the top level with a done-handshaked state machine, a byte timeout and frame statistics.

---
 rtl/uart_frame_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_frame_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_scheduler.sv
// uart_frame_scheduler
//
// Purpose: on a fixed period, snapshots the most recent 16-bit XADC sample and
// feeds it to a UART transmitter as a 6-byte ASCII frame: four uppercase hex
// digits (most significant nibble first) followed by CR (0x0D) and LF (0x0A).
// Each byte is handed over with a one-cycle start pulse, and the scheduler then
// waits for the transmitter's done pulse. A byte that is not acknowledged
// within TIMEOUT cycles abandons the frame and sets a sticky error flag.
//
// Parameters:
//   PERIOD   cycles between frame-start opportunities (>= 2)
//   TIMEOUT  cycles allowed from a byte's start pulse to its done pulse (>= 2)
//
// Ports:
//   clk_i           system clock, rising edge
//   reset_ni        asynchronous active-low reset
//   enable_i        1 = new frames may be scheduled
//   sample_i        XADC sample
//   sample_valid_i  1-cycle strobe qualifying sample_i
//   tx_done_i       1-cycle pulse from the transmitter: current byte finished
//   clear_err_i     clears timeout_err_o
//   tx_data_o       byte to the transmitter, stable from start pulse to next
//   tx_start_o      1-cycle start pulse to the transmitter
//   busy_o          frame in progress
//   frame_done_o    1-cycle pulse when a frame has been fully sent
//   timeout_err_o   sticky: a byte timed out
//   frame_count_o   completed frames, wraps 255 -> 0
module uart_frame_scheduler #(
  parameter int PERIOD  = 65520,
  parameter int TIMEOUT = 200000
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        enable_i,
  input  logic [15:0] sample_i,
  input  logic        sample_valid_i,
  input  logic        tx_done_i,
  input  logic        clear_err_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_start_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        timeout_err_o,
  output logic [7:0]  frame_count_o
);

  localparam int TW = $clog2(PERIOD);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(PERIOD - 1);
  // The wait counter holds the number of WAIT cycles already elapsed before
  // the current one. Giving up when it reads TIMEOUT-2 puts the scheduler back
  // in IDLE exactly TIMEOUT cycles after the byte's start-pulse cycle.
  localparam logic [WW-1:0] WAIT_LAST   = WW'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          due_q, due_d;
  logic          have_sample_q, have_sample_d;
  logic [15:0]   held_q, held_d;
  logic [15:0]   snap_q, snap_d;
  logic [2:0]    index_q, index_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          timeout_err_q, timeout_err_d;
  logic [7:0]    frame_count_q, frame_count_d;

  logic          wrap;
  logic          start;

  function automatic logic [7:0] ascii_hex(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    return 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [7:0] frame_byte(input logic [15:0] v, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = ascii_hex(v[15:12]);
      3'd1:    b = ascii_hex(v[11:8]);
      3'd2:    b = ascii_hex(v[7:4]);
      3'd3:    b = ascii_hex(v[3:0]);
      3'd4:    b = 8'h0D;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    due_d         = due_q;
    have_sample_d = have_sample_q;
    held_d        = held_q;
    snap_d        = snap_q;
    index_d       = index_q;
    wait_d        = wait_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    timeout_err_d = timeout_err_q;
    frame_count_d = frame_count_q;

    // Period timer only runs while scheduling is enabled.
    wrap = enable_i && (timer_q == PERIOD_LAST);
    if (!enable_i || wrap) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    if (sample_valid_i) begin
      held_d        = sample_i;
      have_sample_d = 1'b1;
    end

    // A same-cycle strobe counts as "have a sample" and is what gets sent.
    start = (state_q == ST_IDLE) && enable_i && due_q && (have_sample_q || sample_valid_i);

    // Clear first so a timeout in the same cycle overrides it below.
    if (clear_err_i) begin
      timeout_err_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_d  = sample_valid_i ? sample_i : held_q;
          due_d   = 1'b0;
          index_d = 3'd0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        wait_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wait_d = wait_q + WW'(1);
        if (tx_done_i) begin
          if (index_q == 3'd5) begin
            state_d       = ST_IDLE;
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 8'd1;
          end else begin
            index_d = index_q + 3'd1;
            state_d = ST_SEND;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A wrap in the same cycle as a frame start re-arms the next period.
    if (wrap) begin
      due_d = 1'b1;
    end

    // Outputs are registered from the next state so the start pulse and the
    // byte appear in the SEND cycle itself.
    if (state_d == ST_SEND) begin
      tx_start_d = 1'b1;
      tx_data_d  = frame_byte(snap_d, index_d);
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      due_q         <= 1'b0;
      have_sample_q <= 1'b0;
      held_q        <= 16'h0000;
      snap_q        <= 16'h0000;
      index_q       <= 3'd0;
      wait_q        <= '0;
      tx_data_q     <= 8'h00;
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      frame_count_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      due_q         <= due_d;
      have_sample_q <= have_sample_d;
      held_q        <= held_d;
      snap_q        <= snap_d;
      index_q       <= index_d;
      wait_q        <= wait_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign tx_data_o     = tx_data_q;
  assign tx_start_o    = tx_start_q;
  assign busy_o        = busy_q;
  assign frame_done_o  = frame_done_q;
  assign timeout_err_o = timeout_err_q;
  assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed testbench for uart_frame_scheduler (PERIOD=16, TIMEOUT=50).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_uart_frame_scheduler;
  localparam int PERIOD  = 16;
  localparam int TIMEOUT = 50;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] sample = 16'h0000;
  logic        sample_valid = 1'b0;
  logic        tx_done = 1'b0;
  logic        clear_err = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        busy;
  logic        frame_done;
  logic        timeout_err;
  logic [7:0]  frame_count;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_count = 8'd0;

  always #5 clk = ~clk;

  uart_frame_scheduler #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .enable_i       (enable),
    .sample_i       (sample),
    .sample_valid_i (sample_valid),
    .tx_done_i      (tx_done),
    .clear_err_i    (clear_err),
    .tx_data_o      (tx_data),
    .tx_start_o     (tx_start),
    .busy_o         (busy),
    .frame_done_o   (frame_done),
    .timeout_err_o  (timeout_err),
    .frame_count_o  (frame_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " tx_data"},     {8'h00, tx_data}, 16'h0000);
    chk({tag, " tx_start"},    {15'h0, tx_start}, 16'h0000);
    chk({tag, " busy"},        {15'h0, busy}, 16'h0000);
    chk({tag, " frame_done"},  {15'h0, frame_done}, 16'h0000);
    chk({tag, " timeout_err"}, {15'h0, timeout_err}, 16'h0000);
    chk({tag, " frame_count"}, {8'h00, frame_count}, 16'h0000);
  endtask

  task automatic strobe(input logic [15:0] v);
    sample = v;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  // Bounded wait for the next start pulse; the current cycle is examined first.
  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (tx_start !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    chk({tag, " start seen"}, {15'h0, tx_start}, 16'h0001);
  endtask

  // Transmitter model: done pulse sampled 10 cycles after the start cycle.
  task automatic send_byte(input logic [7:0] exp, input string tag, input bit inject,
                           input bit do_strobe, input logic [15:0] sval);
    wait_start(tag);
    chk({tag, " data"}, {8'h00, tx_data}, {8'h00, exp});
    if (inject) tx_done = 1'b1;   // done during SEND must be ignored
    step();
    tx_done = 1'b0;
    if (do_strobe) strobe(sval);
    else step();
    repeat (7) step();
    chk({tag, " data stable"}, {8'h00, tx_data}, {8'h00, exp});
    chk({tag, " busy in wait"}, {15'h0, busy}, 16'h0001);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] bytes, input string tag, input bit inject,
                            input bit stop_after, input int strobe_idx, input logic [15:0] sval);
    for (int i = 0; i < 6; i++) begin
      send_byte(bytes[47-8*i -: 8], $sformatf("%s b%0d", tag, i), inject, (i == strobe_idx), sval);
    end
    exp_count = exp_count + 8'd1;
    chk({tag, " frame_done"},  {15'h0, frame_done}, 16'h0001);
    chk({tag, " busy end"},    {15'h0, busy}, 16'h0000);
    chk({tag, " frame_count"}, {8'h00, frame_count}, {8'h00, exp_count});
    $display("frame %s sent, frame_count=%0d", tag, frame_count);
    if (stop_after) enable = 1'b0;
    if (inject) tx_done = 1'b1;   // done while IDLE must be ignored
    step();
    tx_done = 1'b0;
    chk({tag, " frame_done pulse"}, {15'h0, frame_done}, 16'h0000);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int starts;

    // Reset state
    step();
    chk_zero("reset");
    step();
    reset_n = 1'b1;
    enable  = 1'b1;
    strobe(16'h1A3F);

    // Frame 1A3F
    send_frame({8'h31, 8'h41, 8'h33, 8'h46, 8'h0D, 8'h0A}, "1A3F", 1'b0, 1'b1, -1, 16'h0);

    // 00FF with BEEF strobed during byte 2, then BEEF frame
    strobe(16'h00FF);
    enable = 1'b1;
    send_frame({8'h30, 8'h30, 8'h46, 8'h46, 8'h0D, 8'h0A}, "00FF", 1'b0, 1'b0, 2, 16'hBEEF);
    send_frame({8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A}, "BEEF", 1'b0, 1'b1, -1, 16'h0);

    // Timeout on byte 3
    strobe(16'h1234);
    enable = 1'b1;
    send_byte(8'h31, "to b0", 1'b0, 1'b0, 16'h0);
    send_byte(8'h32, "to b1", 1'b0, 1'b0, 16'h0);
    send_byte(8'h33, "to b2", 1'b0, 1'b0, 16'h0);
    wait_start("to b3");
    chk("to b3 data", {8'h00, tx_data}, 16'h0034);
    repeat (TIMEOUT - 1) step();
    chk("to busy before limit", {15'h0, busy}, 16'h0001);
    chk("to err before limit", {15'h0, timeout_err}, 16'h0000);
    step();
    chk("to busy after limit", {15'h0, busy}, 16'h0000);
    chk("to err set", {15'h0, timeout_err}, 16'h0001);
    chk("to no frame_done", {15'h0, frame_done}, 16'h0000);
    chk("to count kept", {8'h00, frame_count}, {8'h00, exp_count});
    $display("timeout observed, timeout_err=%0d", timeout_err);

    // clear_err clears; timeout with clear_err held: set wins
    clear_err = 1'b1;
    wait_start("to2 b0");
    chk("to2 b0 data", {8'h00, tx_data}, 16'h0031);
    chk("clear_err clears", {15'h0, timeout_err}, 16'h0000);
    repeat (TIMEOUT) step();
    chk("to2 busy after limit", {15'h0, busy}, 16'h0000);
    chk("to2 set beats clear", {15'h0, timeout_err}, 16'h0001);
    step();
    chk("to2 cleared next", {15'h0, timeout_err}, 16'h0000);
    clear_err = 1'b0;
    send_frame({8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A}, "1234", 1'b0, 1'b1, -1, 16'h0);

    // Reset during byte 4
    strobe(16'hC0DE);
    enable = 1'b1;
    send_byte(8'h43, "rst b0", 1'b0, 1'b0, 16'h0);
    send_byte(8'h30, "rst b1", 1'b0, 1'b0, 16'h0);
    send_byte(8'h44, "rst b2", 1'b0, 1'b0, 16'h0);
    send_byte(8'h45, "rst b3", 1'b0, 1'b0, 16'h0);
    wait_start("rst b4");
    chk("rst b4 data", {8'h00, tx_data}, 16'h000D);
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    chk_zero("async reset");
    enable = 1'b0;
    step();
    step();
    chk_zero("held reset");
    reset_n = 1'b1;
    exp_count = 8'd0;
    $display("reset applied mid-frame");

    // enable=0, due=0: no activity for 100 cycles
    starts = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tx_start === 1'b1 || busy === 1'b1) starts++;
    end
    chk("disabled no start", starts[15:0], 16'h0000);

    // enabled, wraps occur, but no sample yet
    enable = 1'b1;
    starts = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tx_start === 1'b1 || busy === 1'b1) starts++;
    end
    chk("no sample no start", starts[15:0], 16'h0000);
    strobe(16'h5A5A);
    chk("start after sample", {15'h0, tx_start}, 16'h0001);
    send_frame({8'h35, 8'h41, 8'h35, 8'h41, 8'h0D, 8'h0A}, "5A5A", 1'b0, 1'b1, -1, 16'h0);

    // After reset: full PERIOD before the first frame
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    enable = 1'b1;
    sample = 16'h0001;
    sample_valid = 1'b1;
    exp_count = 8'd0;
    step();
    sample_valid = 1'b0;
    n = 1;
    while (tx_start !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("first start latency", n[15:0], 16'(PERIOD + 1));
    send_frame({8'h30, 8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A}, "0001", 1'b0, 1'b0, -1, 16'h0);

    // 256 frames with spurious done pulses in SEND and IDLE; count wraps
    for (int f = 0; f < 256; f++) begin
      send_frame({8'h30, 8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A}, $sformatf("wrap%0d", f),
                 1'b1, 1'b0, -1, 16'h0);
    end
    chk("count after wrap", {8'h00, frame_count}, 16'h0001);
    chk("no err after wrap", {15'h0, timeout_err}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
